number_display_addresser: RTL

//  Upstream stage of the digit-font selector: turns the current VGA pixel (iX,iY) and a

---
 rtl/number_display_pkg.sv | 17 +
 rtl/bin_to_bcd_serial.sv | 93 +++++++++
 rtl/number_display_addresser.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/number_display_pkg.sv
// Shared constants and converter state for the score digit addresser.
// Glyph geometry, the blank-digit code and the converter state encoding.
package number_display_pkg;

    localparam int FONT_W      = 32;
    localparam int FONT_H      = 64;
    localparam int FONT_ADDR_W = 11;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter: one binary bit per clock.
// The result on oBcd is valid in the cycle oDone is high.
module bin_to_bcd_serial
    import number_display_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input  logic                  iClock,
    input  logic                  iResetN,
    input  logic                  iStart,
    input  logic [IN_WIDTH-1:0]   iBin,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [4*DIGITS-1:0]   oBcd
);

    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

    conv_state_t           r_state;
    conv_state_t           w_next;
    logic [IN_WIDTH-1:0]   r_bin;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [4*DIGITS-1:0]   w_adj;
    logic [CW-1:0]         r_cnt;
    logic                  w_take;

    // State register
    always_ff @(posedge iClock) begin
        if (!iResetN) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state and status flags; a start is accepted in IDLE or DONE
    always_comb begin
        w_next = r_state;
        oBusy  = 1'b0;
        oDone  = 1'b0;
        w_take = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (iStart) begin
                    w_next = SHIFT;
                    w_take = 1'b1;
                end
            end
            SHIFT: begin
                oBusy = 1'b1;
                if (r_cnt == LAST) w_next = DONE;
            end
            DONE: begin
                oDone = 1'b1;
                if (iStart) begin
                    w_next = SHIFT;
                    w_take = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow after the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Capture operand on start, then shift one bit per SHIFT cycle
    always_ff @(posedge iClock) begin
        if (!iResetN) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_bin <= iBin;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[IN_WIDTH-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign oBcd = r_bcd;

endmodule

// File: rtl/number_display_addresser.sv
// Maps the VGA pixel and a binary score to font address and digit value.
// Digits change only at frame start; leading zeros may be blanked.
module number_display_addresser
    import number_display_pkg::*;
#(
    parameter int IN_WIDTH        = 16,
    parameter int DIGITS          = 5,
    parameter int ORIGIN_X        = 0,
    parameter int ORIGIN_Y        = 0,
    parameter int LEAD_ZERO_BLANK = 1
) (
    input  logic                    iClock,
    input  logic                    iResetN,
    input  logic [9:0]              iX,
    input  logic [9:0]              iY,
    input  logic                    iFrameStart,
    input  logic [IN_WIDTH-1:0]     iNumber,
    input  logic                    iLoad,
    output logic [FONT_ADDR_W-1:0]  oAddress,
    output logic [3:0]              oValue,
    output logic                    oInRegion,
    output logic                    oBusy
);

    localparam logic [9:0]  ORG_X   = 10'(ORIGIN_X);
    localparam logic [9:0]  ORG_Y   = 10'(ORIGIN_Y);
    localparam logic [10:0] FIELD_W = 11'(DIGITS * FONT_W);
    localparam logic [10:0] FIELD_H = 11'(FONT_H);

    logic                   w_busy;
    logic                   w_done;
    logic                   w_idle;
    logic [4*DIGITS-1:0]    w_bcd;
    logic                   w_start;
    logic [IN_WIDTH-1:0]    w_start_bin;

    logic [IN_WIDTH-1:0]    r_req;
    logic                   r_req_valid;
    logic [4*DIGITS-1:0]    r_pend;
    logic                   r_pend_valid;
    logic [4*DIGITS-1:0]    r_disp;
    logic [4*DIGITS-1:0]    w_shown;

    logic [9:0]             w_rx;
    logic [9:0]             w_ry;
    logic                   w_in;
    logic [4:0]             w_idx;
    logic [3:0]             w_val;

    logic [FONT_ADDR_W-1:0] r_addr;
    logic [3:0]             r_value;
    logic                   r_in_a;
    logic                   r_in_b;

    bin_to_bcd_serial #(
        .IN_WIDTH (IN_WIDTH),
        .DIGITS   (DIGITS)
    ) u_bcd (
        .iClock  (iClock),
        .iResetN (iResetN),
        .iStart  (w_start),
        .iBin    (w_start_bin),
        .oBusy   (w_busy),
        .oDone   (w_done),
        .oBcd    (w_bcd)
    );

    assign w_idle = ~w_busy & ~w_done;
    assign oBusy  = w_busy;

    // Start source: a fresh load wins in IDLE, DONE restarts only from the request
    always_comb begin
        w_start     = 1'b0;
        w_start_bin = r_req;
        if (w_idle) begin
            w_start     = iLoad | r_req_valid;
            w_start_bin = iLoad ? iNumber : r_req;
        end else if (w_done) begin
            w_start = r_req_valid;
        end
    end

    // One-deep request holder; later loads overwrite earlier ones
    always_ff @(posedge iClock) begin
        if (!iResetN) begin
            r_req       <= '0;
            r_req_valid <= 1'b0;
        end else if (iLoad && !w_idle) begin
            r_req       <= iNumber;
            r_req_valid <= 1'b1;
        end else if (w_start) begin
            r_req_valid <= 1'b0;
        end
    end

    // Frame commit reads the old pending state before DONE overwrites it
    always_ff @(posedge iClock) begin
        if (!iResetN) begin
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_disp       <= '0;
        end else begin
            if (iFrameStart && r_pend_valid) begin
                r_disp       <= r_pend;
                r_pend_valid <= 1'b0;
            end
            if (w_done) begin
                r_pend       <= w_bcd;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // Leading-zero blanking, scanning from the most significant digit
    always_comb begin
        logic       v_lead;
        logic [3:0] v_nib;
        w_shown = '0;
        v_lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_nib = r_disp[4*i +: 4];
            if (i != 0 && LEAD_ZERO_BLANK != 0 && v_lead && v_nib == 4'd0) begin
                w_shown[4*i +: 4] = BLANK_DIGIT;
            end else begin
                w_shown[4*i +: 4] = v_nib;
                v_lead            = 1'b0;
            end
        end
    end

    // Field hit test and digit select; leftmost column is the MSD
    always_comb begin
        w_rx  = iX - ORG_X;
        w_ry  = iY - ORG_Y;
        w_in  = (iX >= ORG_X) && ({1'b0, w_rx} < FIELD_W) &&
                (iY >= ORG_Y) && ({1'b0, w_ry} < FIELD_H);
        w_idx = w_rx[9:5];
        w_val = BLANK_DIGIT;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx == 5'(DIGITS - 1 - i))
                w_val = w_shown[4*i +: 4];
        end
    end

    // Stage A address/value register plus the extra region delay
    always_ff @(posedge iClock) begin
        if (!iResetN) begin
            r_addr  <= '0;
            r_value <= BLANK_DIGIT;
            r_in_a  <= 1'b0;
            r_in_b  <= 1'b0;
        end else begin
            r_in_a <= w_in;
            r_in_b <= r_in_a;
            if (w_in) begin
                r_addr  <= {w_ry[5:0], w_rx[4:0]};
                r_value <= w_val;
            end else begin
                r_addr  <= '0;
                r_value <= BLANK_DIGIT;
            end
        end
    end

    assign oAddress  = r_addr;
    assign oValue    = r_value;
    assign oInRegion = r_in_b;

endmodule
